// File: rtl/sa_pkg.sv
// Shared definitions for the N x N output-stationary systolic multiplier:
// FSM state encoding and parameter helper functions.
package sa_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  function automatic int saClog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return w;
  endfunction

  // Wide enough to hold N full-width products without loss.
  function automatic int defaultAccW(input int n, input int dataW);
    return 2 * dataW + saClog2(n);
  endfunction

endpackage

// File: rtl/sa_pe.sv
// One processing element: multiply-accumulate on every edge while passing
// the A operand right and the B operand down.
module sa_pe #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 18,
  parameter int SIGNED = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic [ACC_W-1:0]  acc
);

  logic [2*DATA_W-1:0] prodS;
  logic [2*DATA_W-1:0] prodU;
  logic [ACC_W-1:0]    prodExt;

  // The low 2*DATA_W bits of the product of sign-extended operands is the signed product.
  assign prodS = {{DATA_W{a_in[DATA_W-1]}}, a_in} * {{DATA_W{b_in[DATA_W-1]}}, b_in};
  assign prodU = {{DATA_W{1'b0}}, a_in} * {{DATA_W{1'b0}}, b_in};

  always_comb begin
    if (SIGNED != 0) prodExt = ACC_W'($signed(prodS));
    else             prodExt = ACC_W'(prodU);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else begin
      a_out <= a_in;
      b_out <= b_in;
      if (clr) acc <= '0;
      else     acc <= acc + prodExt;
    end
  end

endmodule

// File: rtl/systolic_array_nxn.sv
// N x N output-stationary systolic multiplier: snapshots A and B on start,
// skews them into the grid and pulses done 3N edges after the start edge.
module systolic_array_nxn
  import sa_pkg::*;
#(
  parameter int N      = 3,
  parameter int DATA_W = 8,
  parameter int ACC_W  = defaultAccW(N, DATA_W),
  parameter int SIGNED = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   accumulate,
  input  logic [N*N*DATA_W-1:0]  mat_a,
  input  logic [N*N*DATA_W-1:0]  mat_b,
  output logic                   busy,
  output logic                   done,
  output logic [N*N*ACC_W-1:0]   result
);

  localparam int CNT_W = saClog2(3 * N);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(3 * N - 2);

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  done_q, done_d;
  logic [N*N*DATA_W-1:0] snapA_q, snapB_q;
  logic                  accMode_q;
  logic                  clrAcc;

  logic [DATA_W-1:0] rowEdge_q [N];
  logic [DATA_W-1:0] colEdge_q [N];
  logic [DATA_W-1:0] rowFeed   [N];
  logic [DATA_W-1:0] colFeed   [N];
  logic [DATA_W-1:0] aBus      [N][N+1];
  logic [DATA_W-1:0] bBus      [N+1][N];
  logic [ACC_W-1:0]  accArr    [N][N];

  // RUN lasts 3N-1 edges: feed steps 0..3N-3, then one drain edge for the far corner PE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_LOAD;
      ST_LOAD: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
      ST_RUN: begin
        if (cnt_q == LAST_STEP) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Operands are frozen on the sampling edge so later input changes cannot leak in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snapA_q   <= '0;
      snapB_q   <= '0;
      accMode_q <= 1'b0;
    end else if (state_q == ST_IDLE && start) begin
      snapA_q   <= mat_a;
      snapB_q   <= mat_b;
      accMode_q <= accumulate;
    end
  end

  always_comb begin
    for (int r = 0; r < N; r++) begin
      rowFeed[r] = '0;
      colFeed[r] = '0;
      for (int k = 0; k < N; k++) begin
        if (int'(cnt_q) == r + k) begin
          rowFeed[r] = snapA_q[(r*N + k)*DATA_W +: DATA_W];
          colFeed[r] = snapB_q[(k*N + r)*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Edge registers hold zero outside RUN, so the grid only ever shifts zeros while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        rowEdge_q[i] <= '0;
        colEdge_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        rowEdge_q[i] <= (state_q == ST_RUN) ? rowFeed[i] : '0;
        colEdge_q[i] <= (state_q == ST_RUN) ? colFeed[i] : '0;
      end
    end
  end

  assign clrAcc = (state_q == ST_LOAD) && !accMode_q;
  assign busy   = (state_q != ST_IDLE);
  assign done   = done_q;

  for (genvar c = 0; c < N; c++) begin : gColEdge
    assign bBus[0][c] = colEdge_q[c];
  end

  for (genvar r = 0; r < N; r++) begin : gRow
    assign aBus[r][0] = rowEdge_q[r];
    for (genvar c = 0; c < N; c++) begin : gCol
      sa_pe #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .SIGNED (SIGNED)
      ) uPe (
        .clk   (clk),
        .reset (reset),
        .clr   (clrAcc),
        .a_in  (aBus[r][c]),
        .b_in  (bBus[r][c]),
        .a_out (aBus[r][c+1]),
        .b_out (bBus[r+1][c]),
        .acc   (accArr[r][c])
      );
      assign result[(r*N + c)*ACC_W +: ACC_W] = accArr[r][c];
    end
  end

endmodule

// File: tb/tb_systolic_array_nxn.sv
// Directed bench for systolic_array_nxn: an unsigned and a signed instance
// share stimulus; results are compared against hand-computed matrices.
module tb_systolic_array_nxn;

  localparam int N  = 3;
  localparam int DW = 8;
  localparam int AW = 18;

  logic              clk;
  logic              reset;
  logic              start;
  logic              accumulate;
  logic [N*N*DW-1:0] matA;
  logic [N*N*DW-1:0] matB;
  logic              busyU, doneU, busyS, doneS;
  logic [N*N*AW-1:0] resultU, resultS;

  int vectorsApplied = 0;
  int miscompares    = 0;

  int idMat[9]  = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
  int bSeq[9]   = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
  int bDbl[9]   = '{2, 4, 6, 8, 10, 12, 14, 16, 18};
  int allFF[9]  = '{255, 255, 255, 255, 255, 255, 255, 255, 255};
  int allTwo[9] = '{2, 2, 2, 2, 2, 2, 2, 2, 2};
  int zeros[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
  int c195k[9]  = '{195075, 195075, 195075, 195075, 195075, 195075, 195075, 195075, 195075};
  int threes[9] = '{3, 3, 3, 3, 3, 3, 3, 3, 3};
  int c1530[9]  = '{1530, 1530, 1530, 1530, 1530, 1530, 1530, 1530, 1530};
  int minus6[9] = '{-6, -6, -6, -6, -6, -6, -6, -6, -6};

  systolic_array_nxn #(.N(N), .DATA_W(DW), .ACC_W(AW), .SIGNED(0)) dutU (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .accumulate (accumulate),
    .mat_a      (matA),
    .mat_b      (matB),
    .busy       (busyU),
    .done       (doneU),
    .result     (resultU)
  );

  systolic_array_nxn #(.N(N), .DATA_W(DW), .ACC_W(AW), .SIGNED(1)) dutS (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .accumulate (accumulate),
    .mat_a      (matA),
    .mat_b      (matB),
    .busy       (busyS),
    .done       (doneS),
    .result     (resultS)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [N*N*DW-1:0] packMat(input int v[9]);
    logic [N*N*DW-1:0] m;
    m = '0;
    for (int i = 0; i < 9; i++) m[i*DW +: DW] = 8'(v[i]);
    return m;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectorsApplied++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkResult(input string tag, input logic [N*N*AW-1:0] res, input int expv[9]);
    for (int i = 0; i < 9; i++)
      checkOutput($sformatf("%s[%0d]", tag, i), 32'(res[i*AW +: AW]), 32'(expv[i]) & 32'h3FFFF);
  endtask

  // Launches one operation and waits (bounded) for done; optionally re-pulses start
  // or corrupts mat_a mid-run to show neither affects the running operation.
  task automatic applyStimulus(input logic [N*N*DW-1:0] a, input logic [N*N*DW-1:0] b,
                               input logic acc, input int extraStartAt, input int changeAAt,
                               output int lat, output logic busyOk);
    @(negedge clk);
    matA = a;
    matB = b;
    accumulate = acc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    accumulate = ~acc;
    lat = 0;
    busyOk = 1'b1;
    while (doneU !== 1'b1 && lat < 30) begin
      if (busyU !== 1'b1 || busyS !== 1'b1) busyOk = 1'b0;
      @(negedge clk);
      lat++;
      start = (lat == extraStartAt);
      if (lat == changeAAt) matA = ~matA;
    end
    start = 1'b0;
  endtask

  task automatic checkTiming(input string tag, input int lat, input logic busyOk);
    checkOutput({tag, ".latency"}, 32'(lat), 32'd9);
    checkOutput({tag, ".busyRun"}, 32'(busyOk), 32'd1);
    checkOutput({tag, ".doneS"}, 32'(doneS), 32'd1);
    checkOutput({tag, ".busyDone"}, 32'(busyU), 32'd0);
    @(negedge clk);
    checkOutput({tag, ".doneFall"}, 32'(doneU), 32'd0);
  endtask

  initial begin
    int   lat;
    logic busyOk;
    logic sawDone;

    reset = 1'b1;
    start = 1'b0;
    accumulate = 1'b0;
    matA = '0;
    matB = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst.busy", 32'(busyU), 32'd0);
    checkOutput("rst.done", 32'(doneU), 32'd0);
    checkResult("rst.result", resultU, zeros);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("idle.busy", 32'(busyU), 32'd0);

    $display("[TB] identity x B");
    applyStimulus(packMat(idMat), packMat(bSeq), 1'b0, -1, -1, lat, busyOk);
    checkResult("ident.U", resultU, bSeq);
    checkResult("ident.S", resultS, bSeq);
    checkTiming("ident", lat, busyOk);

    $display("[TB] accumulate onto previous result");
    applyStimulus(packMat(idMat), packMat(bSeq), 1'b1, -1, -1, lat, busyOk);
    checkResult("accum.U", resultU, bDbl);
    checkResult("accum.S", resultS, bDbl);
    checkTiming("accum", lat, busyOk);
    applyStimulus(packMat(idMat), packMat(bSeq), 1'b0, -1, -1, lat, busyOk);
    checkResult("clear.U", resultU, bSeq);
    checkTiming("clear", lat, busyOk);

    $display("[TB] all 0xFF operands");
    applyStimulus(packMat(allFF), packMat(allFF), 1'b0, -1, -1, lat, busyOk);
    checkResult("ff.U", resultU, c195k);
    checkResult("ff.S", resultS, threes);
    checkTiming("ff", lat, busyOk);

    $display("[TB] 0xFF times 0x02");
    applyStimulus(packMat(allFF), packMat(allTwo), 1'b0, -1, -1, lat, busyOk);
    checkResult("neg.U", resultU, c1530);
    checkResult("neg.S", resultS, minus6);
    checkTiming("neg", lat, busyOk);

    $display("[TB] start and mat_a disturbed mid-run");
    applyStimulus(packMat(idMat), packMat(bSeq), 1'b0, 3, 4, lat, busyOk);
    checkResult("disturb.U", resultU, bSeq);
    checkTiming("disturb", lat, busyOk);
    sawDone = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (doneU === 1'b1 || busyU === 1'b1) sawDone = 1'b1;
    end
    checkOutput("disturb.noQueue", 32'(sawDone), 32'd0);

    $display("[TB] reset mid-run");
    @(negedge clk);
    matA = packMat(allFF);
    matB = packMat(allFF);
    accumulate = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("midRst.busy", 32'(busyU), 32'd0);
    checkOutput("midRst.done", 32'(doneU), 32'd0);
    checkResult("midRst.result", resultU, zeros);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    sawDone = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (doneU === 1'b1) sawDone = 1'b1;
    end
    checkOutput("midRst.noDone", 32'(sawDone), 32'd0);
    checkResult("midRst.held", resultU, zeros);
    applyStimulus(packMat(idMat), packMat(bSeq), 1'b0, -1, -1, lat, busyOk);
    checkResult("afterRst.U", resultU, bSeq);
    checkTiming("afterRst", lat, busyOk);

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
